// File: rtl/adder_tb_pkg.sv
// Shared definitions for the adder test top: default lane geometry,
// the result-writer state encoding and a lane extraction helper.
package adder_tb_pkg;

    localparam int BW_DEFAULT = 8;
    localparam int N_DEFAULT  = 4;

    // Widest packed beat and widest single lane the helper can handle.
    localparam int LS_VEC_W  = 512;
    localparam int LS_LANE_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } wr_state_e;

    // Return lane k (bw bits wide) of a packed beat, zero-extended to LS_LANE_W.
    function automatic logic [LS_LANE_W-1:0] lane_slice(
        input logic [LS_VEC_W-1:0] vec,
        input int unsigned         k,
        input int unsigned         bw
    );
        logic [LS_VEC_W-1:0]  shifted;
        logic [LS_LANE_W-1:0] mask;
        shifted = vec >> (k * bw);
        if (bw >= LS_LANE_W) begin
            mask = '1;
        end else begin
            mask = (LS_LANE_W'(1) << bw) - LS_LANE_W'(1);
        end
        return shifted[LS_LANE_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/adder_lane_mux.sv
// Holds one accepted beat and presents a single selected lane of it.
module adder_lane_mux
    import adder_tb_pkg::*;
#(
    parameter int BW = BW_DEFAULT,
    parameter int N  = N_DEFAULT,
    parameter int LW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [N*BW-1:0] load_data,
    input  logic [LW-1:0]   sel,
    output logic [BW-1:0]   lane
);

    // Select space is padded to a power of two so any sel value is defined.
    localparam int NL = 1 << LW;

    logic [N*BW-1:0] shadow_q;
    logic [BW-1:0]   lanes [NL];

    // Capture the beat on accept; it stays stable while its lanes drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (load) begin
            shadow_q <= load_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            if (gi < N) begin : g_real
                assign lanes[gi] = shadow_q[gi*BW +: BW];
            end else begin : g_pad
                assign lanes[gi] = '0;
            end
        end
    endgenerate

    assign lane = lanes[sel];

endmodule

// File: rtl/adder_result_writer.sv
// Serialises beats of N adder results into a single-port result RAM,
// lane 0 first, and flags done once DEPTH results have been written.
module adder_result_writer
    import adder_tb_pkg::*;
#(
    parameter  int BW    = BW_DEFAULT,
    parameter  int N     = N_DEFAULT,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*BW-1:0] in_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [BW-1:0]   wr_data,
    output logic [AW:0]     count,
    output logic            done
);

    localparam int         LW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   PTR_FULL = (AW+1)'(DEPTH);
    localparam logic [LW-1:0] LANE_ONE  = LW'(1);
    localparam logic [LW-1:0] LANE_LAST = LW'(N - 1);

    wr_state_e     state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;      // results issued so far, 0..DEPTH
    logic [LW-1:0] lane_q, lane_d;    // lane currently on the write port
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [BW-1:0] wr_data_q, wr_data_d;

    logic          accept;
    logic          last_lane;
    logic [LW-1:0] mux_sel;
    logic [BW-1:0] mux_lane;

    assign last_lane = (lane_q == LANE_LAST);
    // The register stage looks one lane ahead of what is on the port.
    assign mux_sel   = lane_q + LANE_ONE;

    adder_lane_mux #(
        .BW (BW),
        .N  (N),
        .LW (LW)
    ) u_lane_mux (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (in_data),
        .sel       (mux_sel),
        .lane      (mux_lane)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every transition.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (last_lane) begin
                        state_d = (ptr_q == PTR_FULL) ? ST_FULL : ST_IDLE;
                    end
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs; a beat is never taken in the cycle clear is high.
    always_comb begin
        in_ready = (state_q == ST_IDLE) && !clear;
        done     = (state_q == ST_FULL);
        accept   = in_valid && in_ready;
    end

    // Write-port next values: lane 0 comes straight from the accepted beat,
    // later lanes come from the shadow copy.
    always_comb begin
        ptr_d     = ptr_q;
        lane_d    = lane_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (clear) begin
            ptr_d     = '0;
            lane_d    = '0;
            wr_addr_d = '0;
            wr_data_d = '0;
        end else if (state_q == ST_IDLE && accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q[AW-1:0];
            wr_data_d = BW'(lane_slice(LS_VEC_W'(in_data), 0, BW));
            ptr_d     = ptr_q + PTR_ONE;
            lane_d    = '0;
        end else if (state_q == ST_WRITE && !last_lane) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q[AW-1:0];
            wr_data_d = mux_lane;
            ptr_d     = ptr_q + PTR_ONE;
            lane_d    = lane_q + LANE_ONE;
        end
    end

    // Write-port and pointer registers; reset drops any in-flight write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            lane_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            lane_q    <= lane_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign count   = ptr_q;

endmodule

// File: tb/tb_adder_result_writer.sv
// Bench for adder_result_writer: transaction-queue reference model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_adder_result_writer;

    localparam int BW    = 8;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic [N*BW-1:0] in_data = '0;
    logic            in_ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [BW-1:0]   wr_data;
    logic [AW:0]     count;
    logic            done;

    always #5 clk = ~clk;

    adder_result_writer #(
        .BW    (BW),
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .count    (count),
        .done     (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Each accepted beat becomes N write transactions plus one idle slot;
    // one entry leaves the queue per clock and is what the write port shows.
    typedef struct {
        bit en;
        int addr;
        int data;
    } wr_t;

    wr_t        m_q[$];
    int         m_count = 0;
    bit         m_full  = 1'b0;
    bit         m_en    = 1'b0;
    int         m_addr  = 0;
    int         m_data  = 0;
    logic [7:0] m_ram   [DEPTH];
    logic [7:0] dut_ram [DEPTH];
    bit         m_ready;
    wr_t        m_w;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_ram[i]   = 8'h00;
            dut_ram[i] = 8'h00;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_count = 0;
            m_full  = 1'b0;
            m_en    = 1'b0;
            m_addr  = 0;
            m_data  = 0;
        end else begin
            m_ready = (m_q.size() == 0) && !m_full && !clear;
            if (clear) begin
                m_q.delete();
                m_count = 0;
                m_full  = 1'b0;
                m_en    = 1'b0;
            end else begin
                if (in_valid && m_ready) begin
                    for (int k = 0; k < N; k++) begin
                        m_q.push_back('{1'b1, m_count + k, int'((in_data >> (BW * k)) & 32'hff)});
                    end
                    m_q.push_back('{1'b0, 0, 0});
                end
                if (m_q.size() > 0) begin
                    m_w  = m_q.pop_front();
                    m_en = m_w.en;
                    if (m_w.en) begin
                        m_addr = m_w.addr;
                        m_data = m_w.data;
                        m_ram[m_w.addr] = 8'(m_w.data);
                        m_count++;
                    end else if (m_count == DEPTH) begin
                        m_full = 1'b1;
                    end
                end else begin
                    m_en = 1'b0;
                end
            end
        end
    end

    // Behavioural RAM fed by the DUT write port.
    always @(posedge clk) begin
        if (rst_n && wr_en) dut_ram[wr_addr] <= wr_data;
    end

    // Per-cycle compare, mid-cycle after inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("cmp_wr_en", 32'(wr_en), 32'(m_en));
            check("cmp_count", 32'(count), 32'(m_count));
            check("cmp_done", 32'(done), 32'(m_full));
            check("cmp_in_ready", 32'(in_ready),
                  32'((m_q.size() == 0) && !m_full && !clear));
            if (m_en) begin
                check("cmp_wr_addr", 32'(wr_addr), 32'(m_addr));
                check("cmp_wr_data", 32'(wr_data), 32'(m_data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer a beat until accepted; returns at the negedge after the accept edge.
    task automatic send_beat(input logic [31:0] d);
        bit r;
        bit got;
        got      = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            #1 r = in_ready;
            @(posedge clk);
            got = r;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("accept_within_bound", 32'(got), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        bit r;
        bit acc_last;
        int seen;
        int nb;
        int guard;
        int acc_t [2];

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat
        send_beat(32'h44332211);
        for (int i = 0; i < N; i++) begin
            #2;
            check("single_wr_en", 32'(wr_en), 32'd1);
            check("single_addr", 32'(wr_addr), 32'(i));
            check("single_data", 32'(wr_data), 32'((i + 1) * 8'h11));
            check("single_busy", 32'(in_ready), 32'd0);
            tick();
        end
        #2;
        check("single_end_wr_en", 32'(wr_en), 32'd0);
        check("single_ready_back", 32'(in_ready), 32'd1);
        check("single_count", 32'(count), 32'd4);
        check("single_done", 32'(done), 32'd0);
        check("model_count_pin", 32'(m_count), 32'd4);

        // Fill: restart, two beats 01..04 and 05..08
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send_beat(32'h04030201);
        send_beat(32'h08070605);
        repeat (N + 1) tick();
        #2;
        check("fill_done", 32'(done), 32'd1);
        check("fill_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_ram", 32'(dut_ram[i]), 32'(i + 1));
            check("model_ram_pin", 32'(m_ram[i]), 32'(i + 1));
        end
        // Third beat while full is ignored
        in_data  = 32'hAABBCCDD;
        in_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            #2;
            if (wr_en) seen++;
        end
        check("full_no_write", 32'(seen), 32'd0);
        check("full_count_held", 32'(count), 32'(DEPTH));

        // Clear together with valid while full
        clear = 1'b1;
        #1;
        check("clrv_ready_low", 32'(in_ready), 32'd0);
        tick();
        #2;
        check("clrv_done", 32'(done), 32'd0);
        check("clrv_count", 32'(count), 32'd0);
        check("clrv_wr_en", 32'(wr_en), 32'd0);
        clear = 1'b0;

        // Backpressure: valid held, new data after each accept
        in_data = $urandom;
        nb = 0;
        guard = 0;
        while (nb < 2 && guard < 40) begin
            #1 r = in_ready;
            @(posedge clk);
            if (r) begin
                acc_t[nb] = cyc;
                nb++;
            end
            @(negedge clk);
            if (r) in_data = $urandom;
            guard++;
        end
        in_valid = 1'b0;
        check("bp_accepts", 32'(nb), 32'd2);
        if (nb == 2) check("bp_spacing", 32'(acc_t[1] - acc_t[0]), 32'(N + 1));
        repeat (N + 1) tick();
        #2;
        check("bp_full", 32'(done), 32'd1);

        // Clear on the 2nd write cycle of a beat
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send_beat($urandom);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #2;
        check("midclr_wr_en", 32'(wr_en), 32'd0);
        check("midclr_count", 32'(count), 32'd0);
        check("midclr_done", 32'(done), 32'd0);
        send_beat(32'h5A6B7C8D);
        #2;
        check("midclr_restart_addr", 32'(wr_addr), 32'd0);
        check("midclr_restart_data", 32'(wr_data), 32'h8D);

        // Async reset during WRITE
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(wr_en), 32'd0);
        check("arst_wr_addr", 32'(wr_addr), 32'd0);
        check("arst_wr_data", 32'(wr_data), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(32'h13243546);
        #2;
        check("arst_restart_addr", 32'(wr_addr), 32'd0);
        check("arst_restart_data", 32'(wr_data), 32'h46);
        tick();

        // Randomized phase: producer holds a beat until it is taken
        acc_last = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 1) == 1);
                in_data  = $urandom;
            end
            clear = ($urandom_range(0, 29) == 0) || (done && $urandom_range(0, 3) == 0);
            #1 r = in_ready;
            @(posedge clk);
            acc_last = r && in_valid;
            @(negedge clk);
        end
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (N + 2) tick();
        for (int i = 0; i < DEPTH; i++) begin
            check("final_ram", 32'(dut_ram[i]), 32'(m_ram[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
